uart_receiver: RTL and testbench

//  Serial-to-parallel end of the UART link: recovers frames from uart_rxd (or the looped-back tx line),

---
 rtl/uart_receiver.sv | 202 ++++++++++++++++++++
 tb/tb_uart_receiver.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receive path: oversampled start/data/parity/stop recovery with parity, framing and break flags.
// Build option RX_MAJORITY_VOTE_EN: each bit decided by a 3-sample majority around its centre.
module uart_receiver #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       pclk,
    input  logic       urrst,
    input  logic       receive_edge,
    input  logic       uart_rxd,
    input  logic       loop,
    input  logic       loop_txd,
    input  logic [1:0] wls,
    input  logic       pen,
    input  logic       eps,
    input  logic       sp,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       pe,
    output logic       fe,
    output logic       bi,
    output logic       rx_busy
);
    // state  | meaning
    // IDLE   | waiting for a 1->0 edge on the synced line
    // START  | qualifying the start bit at its centre
    // DATA   | collecting 5..8 data bits, LSB first
    // PARITY | capturing the parity bit
    // STOP   | sampling the first stop bit and reporting the frame
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam int SC_W = $clog2(OVERSAMPLE);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
    localparam logic [SC_W-1:0] SC_HALF = SC_W'(OVERSAMPLE / 2 - 1);

`ifdef RX_MAJORITY_VOTE_EN
    // Decision lands one tick after the centre; sc keeps its phase across START->DATA.
    localparam logic [SC_W-1:0] START_V0   = SC_W'(OVERSAMPLE / 2 - 2);
    localparam logic [SC_W-1:0] START_V1   = SC_HALF;
    localparam logic [SC_W-1:0] START_DEC  = SC_W'(OVERSAMPLE / 2);
    localparam logic [SC_W-1:0] BIT_V0     = SC_W'(OVERSAMPLE - 2);
    localparam logic [SC_W-1:0] BIT_V1     = SC_LAST;
    localparam logic [SC_W-1:0] BIT_DEC    = '0;
    localparam logic [SC_W-1:0] START_EXIT = SC_W'(1);
`else
    localparam logic [SC_W-1:0] START_DEC  = SC_HALF;
    localparam logic [SC_W-1:0] BIT_DEC    = SC_LAST;
    localparam logic [SC_W-1:0] START_EXIT = '0;
`endif

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   line_raw;
    logic                   line_s;
    logic                   line_prev;
    state_t                 state;
    state_t                 state_next;
    logic [SC_W-1:0]        sc;
    logic [SC_W-1:0]        sc_next;
    logic [2:0]             bit_cnt;
    logic [2:0]             last_bit;
    logic [7:0]             data_sr;
    logic                   par_bit;
    logic                   bit_val;
    logic                   exp_par;
    logic                   start_ok;
    logic                   bit_load;
    logic                   par_load;
    logic                   frame_done;

    assign line_raw = loop ? loop_txd : uart_rxd;
    assign line_s   = sync_ff[SYNC_STAGES-1];
    assign last_bit = 3'd4 + {1'b0, wls};
    assign rx_busy  = (state != IDLE);

`ifdef RX_MAJORITY_VOTE_EN
    logic vote_a;
    logic vote_b;

    always_ff @(posedge pclk) begin
        if (urrst) begin
            vote_a <= 1'b1;
            vote_b <= 1'b1;
        end else if (receive_edge) begin
            if (sc == ((state == START) ? START_V0 : BIT_V0)) vote_a <= line_s;
            if (sc == ((state == START) ? START_V1 : BIT_V1)) vote_b <= line_s;
        end
    end

    assign bit_val = (vote_a & vote_b) | (vote_a & line_s) | (vote_b & line_s);
`else
    assign bit_val = line_s;
`endif

    always_comb begin
        case ({sp, eps})
            2'b00:   exp_par = ~^data_sr;
            2'b01:   exp_par = ^data_sr;
            2'b10:   exp_par = 1'b1;
            default: exp_par = 1'b0;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (urrst) begin
            sync_ff   <= '1;
            line_prev <= 1'b1;
            state     <= IDLE;
            sc        <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], line_raw};
            state   <= state_next;
            sc      <= sc_next;
            if (receive_edge) line_prev <= line_s;
        end
    end

    always_comb begin
        state_next = state;
        sc_next    = sc;
        start_ok   = 1'b0;
        bit_load   = 1'b0;
        par_load   = 1'b0;
        frame_done = 1'b0;
        if (receive_edge) begin
            sc_next = sc + 1'b1;
            case (state)
                IDLE: begin
                    sc_next = '0;
                    if (line_prev && !line_s) state_next = START;
                end
                START: begin
                    if (sc == START_DEC) begin
                        if (bit_val) begin
                            state_next = IDLE;
                            sc_next    = '0;
                        end else begin
                            state_next = DATA;
                            sc_next    = START_EXIT;
                            start_ok   = 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (sc == BIT_DEC) begin
                        bit_load = 1'b1;
                        // >= keeps a mid-frame wls change from running past 8 bits
                        if (bit_cnt >= last_bit) state_next = pen ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (sc == BIT_DEC) begin
                        par_load   = 1'b1;
                        state_next = STOP;
                    end
                end
                STOP: begin
                    if (sc == BIT_DEC) begin
                        frame_done = 1'b1;
                        state_next = IDLE;
                        sc_next    = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    sc_next    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (urrst) begin
            bit_cnt  <= '0;
            data_sr  <= '0;
            par_bit  <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            pe       <= 1'b0;
            fe       <= 1'b0;
            bi       <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (start_ok) begin
                bit_cnt <= '0;
                data_sr <= '0;
            end
            if (bit_load) begin
                data_sr[bit_cnt] <= bit_val;
                bit_cnt          <= bit_cnt + 1'b1;
            end
            if (par_load) par_bit <= bit_val;
            if (frame_done) begin
                rx_valid <= 1'b1;
                rx_data  <= data_sr;
                fe       <= ~bit_val;
                pe       <= pen & (par_bit != exp_par);
                bi       <= (data_sr == 8'h00) & (~pen | ~par_bit) & ~bit_val;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: expected records queued at stimulus, compared per received frame.
module tb_uart_receiver;
    localparam int OS = 16;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       bi;
    } rec_t;

    logic       pclk         = 1'b0;
    logic       urrst        = 1'b1;
    logic       receive_edge = 1'b0;
    logic       uart_rxd     = 1'b1;
    logic       loop         = 1'b0;
    logic       loop_txd     = 1'b1;
    logic [1:0] wls          = 2'b11;
    logic       pen          = 1'b0;
    logic       eps          = 1'b0;
    logic       sp           = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       pe;
    logic       fe;
    logic       bi;
    logic       rx_busy;

    rec_t exp_q[$];
    rec_t obs_q[$];
    int   checks      = 0;
    int   passes      = 0;
    int   busy_cycles = 0;
    int   tick_div    = 0;
    bit   use_loop    = 1'b0;

    uart_receiver #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
        .pclk(pclk), .urrst(urrst), .receive_edge(receive_edge), .uart_rxd(uart_rxd),
        .loop(loop), .loop_txd(loop_txd), .wls(wls), .pen(pen), .eps(eps), .sp(sp),
        .rx_data(rx_data), .rx_valid(rx_valid), .pe(pe), .fe(fe), .bi(bi), .rx_busy(rx_busy)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        tick_div     = (tick_div + 1) % 4;
        receive_edge = (tick_div == 0);
    end

    always @(negedge pclk) begin
        if (rx_valid === 1'b1) obs_q.push_back({rx_data, pe, fe, bi});
        if (rx_busy === 1'b1) busy_cycles++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge pclk);
            while (receive_edge !== 1'b1) @(posedge pclk);
        end
        #1;
    endtask

    task automatic set_line(input logic b);
        if (use_loop) loop_txd = b;
        else uart_rxd = b;
    endtask

    task automatic send_bit(input logic b);
        set_line(b);
        wait_ticks(OS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] w, input logic with_par,
                              input logic par, input logic stop, input int glitch);
        send_bit(1'b0);
        for (int i = 0; i < 5 + int'(w); i++) begin
            if (i == glitch) begin
                set_line(d[i]);
                wait_ticks(OS / 2);
                set_line(~d[i]);
                wait_ticks(1);
                set_line(d[i]);
                wait_ticks(OS / 2 - 1);
            end else begin
                send_bit(d[i]);
            end
        end
        if (with_par) send_bit(par);
        send_bit(stop);
    endtask

    task automatic collect(output rec_t e, output rec_t o, output bit got);
        int n;
        n   = 0;
        got = 1'b0;
        e   = '0;
        o   = '0;
        while (obs_q.size() == 0 && n < 400) begin
            @(negedge pclk);
            n++;
        end
        if (obs_q.size() != 0 && exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            o   = obs_q.pop_front();
            got = 1'b1;
        end
    endtask

    task automatic test_reset();
        urrst = 1'b1;
        repeat (5) @(posedge pclk);
        @(negedge pclk);
        checks++;
        if ({rx_valid, rx_busy, pe, fe, bi} !== 5'b00000)
            $display("FAIL reset_flags: observed %b required 00000", {rx_valid, rx_busy, pe, fe, bi});
        else passes++;
        checks++;
        if (rx_data !== 8'h00) $display("FAIL reset_data: observed %h required 00", rx_data);
        else passes++;
        urrst = 1'b0;
        wait_ticks(4);
    endtask

    task automatic test_8n1();
        rec_t e, o;
        bit   got;
        wls = 2'b11; pen = 1'b0; eps = 1'b0; sp = 1'b0;
        busy_cycles = 0;
        exp_q.push_back({8'hA5, 3'b000});
        send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b1, -1);
        collect(e, o, got);
        checks++;
        if (!got || o !== e) $display("FAIL 8n1_a5: got=%0b observed %h required %h", got, o, e);
        else passes++;
        checks++;
        if (busy_cycles < 600 || busy_cycles > 620)
            $display("FAIL 8n1_busy_len: observed %0d cycles required 600..620", busy_cycles);
        else passes++;
        wait_ticks(OS);
        checks++;
        if (obs_q.size() != 0) $display("FAIL 8n1_single: observed %0d extra frames required 0", obs_q.size());
        else passes++;
    endtask

    task automatic test_parity();
        rec_t e, o;
        bit   got;
        wls = 2'b10; pen = 1'b1; eps = 1'b1; sp = 1'b0;
        exp_q.push_back({8'h35, 3'b000});
        send_frame(8'h35, 2'b10, 1'b1, 1'b0, 1'b1, -1);
        collect(e, o, got);
        checks++;
        if (!got || o !== e) $display("FAIL 7e1_good: got=%0b observed %h required %h", got, o, e);
        else passes++;
        exp_q.push_back({8'h35, 3'b100});
        send_frame(8'h35, 2'b10, 1'b1, 1'b1, 1'b1, -1);
        collect(e, o, got);
        checks++;
        if (!got || o !== e) $display("FAIL 7e1_bad: got=%0b observed %h required %h", got, o, e);
        else passes++;
    endtask

    task automatic test_stick();
        rec_t e, o;
        bit   got;
        wls = 2'b00; pen = 1'b1; sp = 1'b1; eps = 1'b0;
        exp_q.push_back({8'h1F, 3'b100});
        send_frame(8'h1F, 2'b00, 1'b1, 1'b0, 1'b1, -1);
        collect(e, o, got);
        checks++;
        if (!got || o !== e) $display("FAIL stick1_par0: got=%0b observed %h required %h", got, o, e);
        else passes++;
        eps = 1'b1;
        exp_q.push_back({8'h1F, 3'b000});
        send_frame(8'h1F, 2'b00, 1'b1, 1'b0, 1'b1, -1);
        collect(e, o, got);
        checks++;
        if (!got || o !== e) $display("FAIL stick0_par0: got=%0b observed %h required %h", got, o, e);
        else passes++;
    endtask

    task automatic test_break();
        rec_t e, o;
        bit   got;
        wls = 2'b11; pen = 1'b0; eps = 1'b0; sp = 1'b0;
        exp_q.push_back({8'h00, 3'b011});
        set_line(1'b0);
        wait_ticks(12 * OS);
        collect(e, o, got);
        checks++;
        if (!got || o !== e) $display("FAIL break_frame: got=%0b observed %h required %h", got, o, e);
        else passes++;
        set_line(1'b1);
        wait_ticks(3 * OS);
        checks++;
        if (obs_q.size() != 0) $display("FAIL break_single: observed %0d extra frames required 0", obs_q.size());
        else passes++;
        exp_q.push_back({8'h81, 3'b000});
        send_frame(8'h81, 2'b11, 1'b0, 1'b0, 1'b1, -1);
        collect(e, o, got);
        checks++;
        if (!got || o !== e) $display("FAIL break_recover: got=%0b observed %h required %h", got, o, e);
        else passes++;
    endtask

    task automatic test_glitch();
        set_line(1'b0);
        wait_ticks(4);
        set_line(1'b1);
        wait_ticks(2 * OS);
        checks++;
        if (obs_q.size() != 0) $display("FAIL false_start_valid: observed %0d frames required 0", obs_q.size());
        else passes++;
        checks++;
        if (rx_busy !== 1'b0) $display("FAIL false_start_busy: observed %b required 0", rx_busy);
        else passes++;
`ifdef RX_MAJORITY_VOTE_EN
        begin
            rec_t e, o;
            bit   got;
            exp_q.push_back({8'h96, 3'b000});
            send_frame(8'h96, 2'b11, 1'b0, 1'b0, 1'b1, 2);
            collect(e, o, got);
            checks++;
            if (!got || o !== e) $display("FAIL vote_glitch: got=%0b observed %h required %h", got, o, e);
            else passes++;
        end
`endif
    endtask

    task automatic test_loop();
        rec_t e, o;
        bit   got;
        wls = 2'b11; pen = 1'b0; eps = 1'b0; sp = 1'b0;
        loop_txd = 1'b1;
        loop     = 1'b1;
        use_loop = 1'b1;
        wait_ticks(2);
        uart_rxd = 1'b0;
        wait_ticks(2 * OS);
        exp_q.push_back({8'h5A, 3'b000});
        send_frame(8'h5A, 2'b11, 1'b0, 1'b0, 1'b1, -1);
        collect(e, o, got);
        checks++;
        if (!got || o !== e) $display("FAIL loop_5a: got=%0b observed %h required %h", got, o, e);
        else passes++;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        set_line(1'b1);
        wait_ticks(OS / 2);
        urrst = 1'b1;
        repeat (2) @(posedge pclk);
        #1 urrst = 1'b0;
        wait_ticks(11 * OS);
        checks++;
        if (obs_q.size() != 0) $display("FAIL reset_midframe_valid: observed %0d frames required 0", obs_q.size());
        else passes++;
        checks++;
        if (rx_data !== 8'h00 || rx_busy !== 1'b0)
            $display("FAIL reset_midframe_state: observed data=%h busy=%b required 00/0", rx_data, rx_busy);
        else passes++;
        exp_q.push_back({8'h3C, 3'b000});
        send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b1, -1);
        collect(e, o, got);
        checks++;
        if (!got || o !== e) $display("FAIL loop_3c: got=%0b observed %h required %h", got, o, e);
        else passes++;
    endtask

    task automatic test_back_to_back();
        rec_t       e, o;
        bit         got;
        logic [7:0] d;
        logic [7:0] m;
        logic [1:0] w;
        logic       p_en, e_ps, s_p, flip, good, par;
        uart_rxd = 1'b1;
        wait_ticks(2);
        loop     = 1'b0;
        use_loop = 1'b0;
        wait_ticks(2 * OS);
        for (int k = 0; k < 8; k++) begin
            w    = 2'($urandom_range(0, 3));
            m    = 8'((1 << (5 + int'(w))) - 1);
            d    = 8'($urandom) & m;
            p_en = 1'($urandom_range(0, 1));
            e_ps = 1'($urandom_range(0, 1));
            s_p  = 1'($urandom_range(0, 1));
            flip = 1'($urandom_range(0, 1));
            if (s_p) good = (e_ps == 1'b0);
            else if (e_ps) good = ($countones(d) % 2 == 1);
            else good = ($countones(d) % 2 == 0);
            par = flip ? ~good : good;
            wls = w; pen = p_en; eps = e_ps; sp = s_p;
            exp_q.push_back({d, p_en & flip, 2'b00});
            send_frame(d, w, p_en, par, 1'b1, -1);
            collect(e, o, got);
            checks++;
            if (!got || o !== e)
                $display("FAIL b2b_frame%0d: got=%0b observed %h required %h (wls=%b pen=%b eps=%b sp=%b)",
                         k, got, o, e, w, p_en, e_ps, s_p);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_stick();
        test_break();
        test_glitch();
        test_loop();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
